lane_join_buffer: RTL and testbench
===================================

Name: lane_join_buffer

Overview:
- Upstream aligner for the multi-lane carousel stage.
- Accepts N_LANES independent valid/ready streams, buffers each lane in a small FIFO, and presents one aligned bundle when every lane holds a head entry.
- The downstream carousel therefore sees all lanes valid together and can ingest them in the same cycle.
- Also measures inter-lane arrival skew and flags excessive skew.

Parameters:
N_LANES, 3, number of lanes (>=2)
DATA_WIDTH, 8, bits per lane entry
DEPTH, 2, entries per lane FIFO; power of 2, >=2
CNT_W, 8, skew counter width
MAX_SKEW, 16, skew threshold in cycles that sets skew_err; must be <= 2^CNT_W-1

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-low
data_in  input  N_LANES*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
data_in_valid  input  N_LANES  per-lane valid
data_in_ready  output  N_LANES  per-lane ready
data_out  output  N_LANES*DATA_WIDTH  aligned bundle, lane-packed like data_in
data_out_valid  output  1  bundle valid
data_out_ready  input  1  bundle accepted by downstream
skew_cnt  output  CNT_W  cycles spent in PARTIAL during the current bundle
skew_err  output  1  sticky excessive-skew flag
err_clear  input  1  clears skew_err

Behaviour:
- Reset (rst==0 at clk edge): all FIFO pointers and counts go to zero; state=IDLE; skew_cnt=0; skew_err=0.
- While rst==0, data_in_ready is forced to all-zero; data_out_valid=0.
- Lane push: push when data_in_valid[i] && data_in_ready[i].
- data_in_ready[i] = !full[i] and is registered-state only; it has no combinational path from data_out_ready.
- A full lane does not accept a push in the same cycle it is popped; it re-asserts ready the next cycle.
- data_out_valid = AND over all lanes of !empty[i].
- data_out = FIFO head of each lane, driven combinationally from storage (first-word fall-through).
- Bundle pop: when data_out_valid && data_out_ready, every lane head pops simultaneously.
- No partial pops ever occur. data_out and data_out_valid hold stable while data_out_ready is 0.
- Latency: an entry written at edge t is visible at data_out after edge t, provided all other lanes are non-empty. Minimum input-to-output latency is 1 cycle.
- Simultaneous push and pop on a non-full lane: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Count is held in log2(DEPTH)+1 bits.
- Alignment state machine, evaluated on post-update FIFO occupancy:
  - IDLE: all lanes empty.
  - PARTIAL: at least one lane non-empty and at least one lane empty.
  - ALIGNED: all lanes non-empty.
  - Transitions follow occupancy directly. ALIGNED->PARTIAL occurs after a pop that empties some but not all lanes. ALIGNED->IDLE occurs after a pop that empties every lane.
- skew_cnt:
  - Increments by 1 each cycle the current state is PARTIAL; saturates at 2^CNT_W-1 with no wrap.
  - Holds its value in ALIGNED.
  - Clears to 0 on a bundle pop and on any cycle in IDLE.
- skew_err:
  - Set when skew_cnt increments to a value >= MAX_SKEW; stays set (sticky).
  - err_clear==1 clears it on that edge. If set and clear occur in the same cycle, set wins.
- Reset mid-operation: all buffered data is discarded and no bundle is emitted. Upstream must re-send.
- Overflow and underflow cannot occur by construction; the bench asserts both.

Decomposition:
- Shared package: the align_state_t enum (IDLE, PARTIAL, ALIGNED) and a lane-slice helper function.
- One sub-module, lane_fifo: parameterized DATA_WIDTH/DEPTH FWFT FIFO with push, pop, full, empty, and head outputs.
- The top instantiates lane_fifo N_LANES times with a generate loop, plus the join, state and skew logic.

Test Plan:
- Reset: hold rst=0 3 cycles with all valids high -> data_in_ready=000, data_out_valid=0, skew_cnt=0; after rst=1, data_in_ready=111.
- Aligned arrival: lanes 0/1/2 push 0x11/0x22/0x33 on the same cycle, data_out_ready=1 -> next cycle data_out_valid=1, data_out=0x332211; popped that cycle; skew_cnt=0 throughout.
- Skewed arrival: lane0 at cycle 0, lane1 at cycle 4, lane2 at cycle 9 -> data_out_valid rises after cycle 9, skew_cnt=9 while held, 0 after pop; skew_err stays 0.
- Excess skew: lane2 delayed 20 cycles with MAX_SKEW=16 -> skew_err=1 from the cycle skew_cnt reaches 16 until err_clear pulses; clear-and-set collision keeps it at 1.
- Backpressure: data_out_ready=0, push 2 entries per lane (DEPTH=2) -> data_in_ready=000, data_out stable at first bundle. Then data_out_ready=1 for 2 cycles -> bundles emitted in order; ready returns one cycle after each pop.
- Mid-operation reset: lanes 0 and 1 hold data, rst=0 for 1 cycle -> FIFOs empty, state IDLE. Later pushes produce a bundle containing only the new data.

Source files
------------

// File: rtl/lane_join_buffer_pkg.sv
// Shared types and helpers for the lane join buffer: alignment states and
// lane-packing arithmetic used by the top and the bench.
package lane_join_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PARTIAL = 2'd1,
        ALIGNED = 2'd2
    } align_state_t;

    // Bit offset of a lane inside a lane-packed bus.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

    // Maps lane occupancy onto the alignment state it implies.
    function automatic align_state_t classify(input logic all_nonempty, input logic all_empty);
        if (all_empty) begin
            return IDLE;
        end
        if (all_nonempty) begin
            return ALIGNED;
        end
        return PARTIAL;
    endfunction

endpackage

// File: rtl/lane_join_buffer_fifo.sv
// First-word fall-through FIFO for one lane; the head word is read straight
// from storage so it is visible the cycle after it was written.
module lane_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty,
    output logic                  empty_next
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic [PTR_W:0]        count_next;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
        end
    end

    // NOTE: storage is deliberately not reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    assign head       = mem[rd_ptr];
    assign full       = (count == FULL_COUNT);
    assign empty      = (count == '0);
    assign empty_next = (count_next == '0);

endmodule

// File: rtl/lane_join_buffer.sv
// Joins N independent lane streams into one aligned bundle and measures how
// long the lanes spend partially filled (inter-lane arrival skew).
module lane_join_buffer #(
    parameter int N_LANES    = 3,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2,
    parameter int CNT_W      = 8,
    parameter int MAX_SKEW   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_LANES*DATA_WIDTH-1:0] data_in,
    input  logic [N_LANES-1:0]            data_in_valid,
    output logic [N_LANES-1:0]            data_in_ready,
    output logic [N_LANES*DATA_WIDTH-1:0] data_out,
    output logic                          data_out_valid,
    input  logic                          data_out_ready,
    output logic [CNT_W-1:0]              skew_cnt,
    output logic                          skew_err,
    input  logic                          err_clear
);

    import lane_join_buffer_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] SKEW_LIMIT = CNT_W'(MAX_SKEW);

    logic [N_LANES-1:0] full;
    logic [N_LANES-1:0] empty;
    logic [N_LANES-1:0] empty_next;
    logic [N_LANES-1:0] push;
    logic               pop;

    align_state_t state;
    align_state_t state_next;

    logic             skew_inc;
    logic [CNT_W-1:0] skew_cnt_plus;

    // Ready depends only on registered fullness, never on data_out_ready.
    assign data_in_ready  = rst ? ~full : '0;
    assign push           = data_in_valid & data_in_ready;
    assign data_out_valid = rst & ~|empty;
    assign pop            = data_out_valid & data_out_ready;

    for (genvar i = 0; i < N_LANES; i++) begin : gen_lane
        lane_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .push       (push[i]),
            .pop        (pop),
            .data_in    (data_in[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
            .head       (data_out[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
            .full       (full[i]),
            .empty      (empty[i]),
            .empty_next (empty_next[i])
        );
    end

    // State tracks the occupancy that results from this cycle's pushes and pops.
    always_comb begin
        state_next = classify(~|empty_next, &empty_next);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        skew_inc      = (state == PARTIAL) && (skew_cnt != CNT_MAX);
        skew_cnt_plus = skew_cnt + 1'b1;
    end

    // A pop cannot coincide with PARTIAL, so clearing before counting is safe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            skew_cnt <= '0;
        end else if (pop || state == IDLE) begin
            skew_cnt <= '0;
        end else if (skew_inc) begin
            skew_cnt <= skew_cnt_plus;
        end
    end

    // Setting takes priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            skew_err <= 1'b0;
        end else if (skew_inc && skew_cnt_plus >= SKEW_LIMIT) begin
            skew_err <= 1'b1;
        end else if (err_clear) begin
            skew_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lane_join_buffer.sv
// Directed bench for lane_join_buffer: reset, alignment, skew, backpressure
// and mid-operation reset, plus a per-cycle occupancy monitor.
module tb_lane_join_buffer;

    import lane_join_buffer_pkg::*;

    localparam int N_LANES    = 3;
    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 2;
    localparam int CNT_W      = 8;
    localparam int MAX_SKEW   = 16;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [N_LANES*DATA_WIDTH-1:0] data_in;
    logic [N_LANES-1:0]            data_in_valid;
    logic [N_LANES-1:0]            data_in_ready;
    logic [N_LANES*DATA_WIDTH-1:0] data_out;
    logic                          data_out_valid;
    logic                          data_out_ready;
    logic [CNT_W-1:0]              skew_cnt;
    logic                          skew_err;
    logic                          err_clear;

    int errors = 0;
    int checks = 0;

    int                 occ [N_LANES];
    logic [N_LANES-1:0] pend_push;
    logic               pend_pop;
    logic               pend_rst;
    logic               exp_valid;

    lane_join_buffer #(
        .N_LANES    (N_LANES),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W),
        .MAX_SKEW   (MAX_SKEW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .skew_cnt       (skew_cnt),
        .skew_err       (skew_err),
        .err_clear      (err_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < N_LANES; i++) occ[i] = 0;
        pend_push = '0;
        pend_pop  = 1'b0;
        pend_rst  = 1'b1;
    end

    // Occupancy model: bundle valid must track "every lane non-empty", and the
    // handshakes must never push into a full lane or pop an empty one.
    always @(negedge clk) begin
        exp_valid = rst;
        for (int i = 0; i < N_LANES; i++) begin
            if (occ[i] == 0) exp_valid = 1'b0;
        end
        check("mon_valid", data_out_valid, exp_valid);
        pend_push = data_in_valid & data_in_ready;
        pend_pop  = data_out_valid & data_out_ready;
        pend_rst  = rst;
        for (int i = 0; i < N_LANES; i++) begin
            check("mon_overflow", pend_push[i] && occ[i] >= DEPTH, 1'b0);
            check("mon_underflow", pend_pop && occ[i] == 0, 1'b0);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N_LANES; i++) begin
            if (!pend_rst) occ[i] = 0;
            else occ[i] = occ[i] + int'(pend_push[i]) - int'(pend_pop);
        end
    end

    initial begin
        rst            = 1'b0;
        data_in        = '0;
        data_in_valid  = '1;
        data_out_ready = 1'b0;
        err_clear      = 1'b0;

        // Reset with all valids high.
        repeat (3) tick();
        check("rst_ready", data_in_ready, 3'b000);
        check("rst_valid", data_out_valid, 1'b0);
        check("rst_skew_cnt", skew_cnt, 0);
        check("rst_skew_err", skew_err, 1'b0);
        data_in_valid = '0;
        rst = 1'b1;
        #1;
        check("post_rst_ready", data_in_ready, 3'b111);

        // Aligned arrival.
        data_in        = 24'h332211;
        data_in_valid  = 3'b111;
        data_out_ready = 1'b1;
        tick();
        data_in_valid = '0;
        check("al_valid", data_out_valid, 1'b1);
        check("al_data", data_out, 24'h332211);
        check("al_skew", skew_cnt, 0);
        tick();
        check("al_popped", data_out_valid, 1'b0);
        check("al_skew_after", skew_cnt, 0);
        data_out_ready = 1'b0;

        // Skewed arrival: lanes at cycles 0, 4 and 9.
        data_in       = 24'h0000A0;
        data_in_valid = 3'b001;
        tick();
        data_in_valid = '0;
        check("sk_cnt0", skew_cnt, 0);
        repeat (3) tick();
        data_in       = 24'h00B000;
        data_in_valid = 3'b010;
        tick();
        data_in_valid = '0;
        check("sk_cnt4", skew_cnt, 4);
        check("sk_valid_mid", data_out_valid, 1'b0);
        repeat (4) tick();
        data_in       = 24'hC00000;
        data_in_valid = 3'b100;
        tick();
        data_in_valid = '0;
        check("sk_valid", data_out_valid, 1'b1);
        check("sk_data", data_out, 24'hC0B0A0);
        check("sk_cnt9", skew_cnt, 9);
        tick();
        check("sk_cnt_hold", skew_cnt, 9);
        data_out_ready = 1'b1;
        tick();
        data_out_ready = 1'b0;
        check("sk_cnt_pop", skew_cnt, 0);
        check("sk_valid_pop", data_out_valid, 1'b0);
        check("sk_err", skew_err, 1'b0);

        // Excess skew: lane2 twenty cycles late.
        data_in       = 24'h000201;
        data_in_valid = 3'b011;
        tick();
        data_in_valid = '0;
        repeat (15) tick();
        check("ex_cnt15", skew_cnt, 15);
        check("ex_err15", skew_err, 1'b0);
        tick();
        check("ex_cnt16", skew_cnt, 16);
        check("ex_err16", skew_err, 1'b1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("ex_collide_err", skew_err, 1'b1);
        check("ex_cnt17", skew_cnt, 17);
        repeat (2) tick();
        data_in       = 24'h030000;
        data_in_valid = 3'b100;
        tick();
        data_in_valid = '0;
        check("ex_cnt20", skew_cnt, 20);
        check("ex_valid", data_out_valid, 1'b1);
        check("ex_data", data_out, 24'h030201);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("ex_cleared", skew_err, 1'b0);
        check("ex_cnt_held", skew_cnt, 20);
        data_out_ready = 1'b1;
        tick();
        data_out_ready = 1'b0;
        check("ex_cnt_pop", skew_cnt, 0);

        // Backpressure: fill both entries of every lane.
        data_in       = 24'h030201;
        data_in_valid = 3'b111;
        tick();
        data_in = 24'h060504;
        tick();
        data_in_valid = '0;
        check("bp_ready_full", data_in_ready, 3'b000);
        check("bp_data_first", data_out, 24'h030201);
        tick();
        check("bp_data_stable", data_out, 24'h030201);
        check("bp_valid_stable", data_out_valid, 1'b1);
        data_out_ready = 1'b1;
        tick();
        check("bp_data_second", data_out, 24'h060504);
        check("bp_ready_back", data_in_ready, 3'b111);
        tick();
        check("bp_drained", data_out_valid, 1'b0);
        data_out_ready = 1'b0;

        // Mid-operation reset discards buffered lanes 0 and 1.
        data_in       = 24'h00BBAA;
        data_in_valid = 3'b011;
        tick();
        data_in_valid = '0;
        rst = 1'b0;
        #1;
        check("mr_ready_low", data_in_ready, 3'b000);
        tick();
        rst = 1'b1;
        check("mr_valid", data_out_valid, 1'b0);
        check("mr_state", dut.state, IDLE);
        check("mr_skew", skew_cnt, 0);
        data_in       = 24'hC30000;
        data_in_valid = 3'b100;
        tick();
        check("mr_lane2_only", data_out_valid, 1'b0);
        data_in       = 24'h00C2C1;
        data_in_valid = 3'b011;
        tick();
        data_in_valid = '0;
        check("mr_valid_new", data_out_valid, 1'b1);
        check("mr_data_new", data_out, 24'hC3C2C1);
        check("mr_skew_new", skew_cnt, 1);
        data_out_ready = 1'b1;
        tick();
        data_out_ready = 1'b0;
        check("mr_popped", data_out_valid, 1'b0);
        check("mr_idle", dut.state, IDLE);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
